// File: rtl/pte_resp_pkg.sv
// Shared types and helpers for the PTE memory responder.
package pte_resp_pkg;

  localparam int LINE_W = 128;
  localparam int TAG_W  = 28;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR      = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Word 0 is bits [31:0], word 3 is bits [127:96].
  function automatic logic [31:0] word_sel(input logic [LINE_W-1:0] line, input logic [1:0] idx);
    return line[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/pte_mem_responder.sv
// PTE walk port responder: single-word accesses mapped onto 128-bit DRAM lines,
// with a one-line read buffer that write-through stores keep coherent.
module pte_mem_responder
  import pte_resp_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic              i_flush,
  output logic              o_busy,
  output logic              o_rvalid,
  output logic [31:0]       o_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [31:0]       o_mem_addr,
  output logic [LINE_W-1:0] o_mem_wdata,
  output logic [15:0]       o_mem_wmask,
  input  logic              i_mem_ack,
  input  logic [LINE_W-1:0] i_mem_rdata
);

  state_e             state_q, state_d;
  logic               buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]   buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]  buf_data_q, buf_data_d;
  logic [1:0]         word_q, word_d;
  logic               busy_q, busy_d;
  logic               rvalid_q, rvalid_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [15:0]        mem_wmask_q, mem_wmask_d;

  logic               req_hit;
  logic               line_hit;
  logic               addr_lsb_unused;

  assign addr_lsb_unused = ^i_addr[1:0];
  assign req_hit  = buf_valid_q && (buf_tag_q == i_addr[31:4]);
  assign line_hit = buf_valid_q && (buf_tag_q == mem_addr_q[31:4]);

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    word_d      = word_q;
    busy_d      = busy_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          word_d = i_addr[3:2];
          if (i_we) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {i_addr[31:4], 4'b0000};
            mem_wdata_d = {4{i_wdata}};
            mem_wmask_d = 16'h000F << {i_addr[3:2], 2'b00};
            busy_d      = 1'b1;
            state_d     = ST_WR;
          end else if (req_hit) begin
            rdata_d  = word_sel(buf_data_q, i_addr[3:2]);
            rvalid_d = 1'b1;
            state_d  = ST_RESP;
          end else begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {i_addr[31:4], 4'b0000};
            mem_wmask_d = 16'h0000;
            busy_d      = 1'b1;
            state_d     = ST_RD_MISS;
          end
        end
      end
      ST_RD_MISS: begin
        if (i_mem_ack) begin
          buf_valid_d = 1'b1;
          buf_tag_d   = mem_addr_q[31:4];
          buf_data_d  = i_mem_rdata;
          rdata_d     = word_sel(i_mem_rdata, word_q);
          rvalid_d    = 1'b1;
          mem_req_d   = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_WR: begin
        if (i_mem_ack) begin
          // Write-through without allocate: only refresh a line we already hold.
          if (line_hit) begin
            buf_data_d[{word_q, 5'b00000} +: 32] = mem_wdata_q[31:0];
          end
          rvalid_d  = 1'b1;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          state_d   = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Flush overrides any fill happening in the same cycle.
    if (i_flush) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wmask = mem_wmask_q;

  // The walker must not issue a request until the responder is back in idle.
  a_no_req_when_busy: assert property (@(posedge CLK) disable iff (RST)
    !(i_req && (busy_q || state_q == ST_RESP)));

endmodule
